// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core: opcodes, controller states, stream markers, ALU ops.
// The packed-int8 ops are enabled by defining VECTOR_OPS_EN.
package cpu_pkg;

  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 32;

  localparam logic [7:0] START = 8'hFE;
  localparam logic [7:0] END   = 8'hFF;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_LUI  = 6'h02;
  localparam logic [5:0] OP_ORI  = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h04;
  localparam logic [5:0] OP_SUB  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h06;
  localparam logic [5:0] OP_SW   = 6'h07;
  localparam logic [5:0] OP_BEQ  = 6'h08;
  localparam logic [5:0] OP_RELU = 6'h10;
  localparam logic [5:0] OP_MAXP = 6'h11;
  localparam logic [5:0] OP_HALT = 6'h3E;

  // Encodings double as the easter_egg output code.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_RUN  = 3'b010,
    ST_HALT = 3'b100,
    ST_TRAP = 3'b111
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_OR   = 3'd2,
    ALU_RELU = 3'd3,
    ALU_MAXP = 3'd4
  } alu_op_e;

endpackage

// File: rtl/cpu_vec_alu.sv
// Combinational datapath: 32-bit ADD/SUB/OR plus lane-wise int8 RELU and MAXP.
// The lane logic only exists when VECTOR_OPS_EN is defined.
module cpu_vec_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] y_o
);

`ifdef VECTOR_OPS_EN
  logic [31:0] relu_y;
  logic [31:0] maxp_y;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] la;
    logic [7:0] lb;
    assign la = a_i[gi*8 +: 8];
    assign lb = b_i[gi*8 +: 8];
    assign relu_y[gi*8 +: 8] = la[7] ? 8'h00 : la;
    assign maxp_y[gi*8 +: 8] = ($signed(la) > $signed(lb)) ? la : lb;
  end
`endif

  always_comb begin
    y_o = a_i + b_i;
    case (op_i)
      ALU_SUB: y_o = a_i - b_i;
      ALU_OR:  y_o = a_i | b_i;
`ifdef VECTOR_OPS_EN
      ALU_RELU: y_o = relu_y;
      ALU_MAXP: y_o = maxp_y;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// Byte-stream-loaded 32-bit in-order core with a combinational byte-wide debug readout.
// Define VECTOR_OPS_EN to enable the RELU/MAXP opcodes; otherwise they trap.
module cpu #(
  parameter int IMEM_WORDS = cpu_pkg::IMEM_WORDS,
  parameter int DMEM_WORDS = cpu_pkg::DMEM_WORDS
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic [7:0] instr_i,
  input  logic       DataOrReg,
  input  logic [4:0] address,
  input  logic [1:0] vout_addr,
  output logic [7:0] value_o,
  output logic       is_positive,
  output logic [2:0] easter_egg
);
  import cpu_pkg::*;

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam logic [IA_W-1:0] PTR_LAST = IA_W'(IMEM_WORDS - 1);
  localparam logic [IA_W-1:0] PTR_ONE  = IA_W'(1);
  localparam logic [IA_W:0]   PC_END   = (IA_W + 1)'(IMEM_WORDS);
  localparam logic [IA_W:0]   PC_ONE   = (IA_W + 1)'(1);

  state_e          state_q, state_d;
  logic [IA_W:0]   pc_q, pc_d;
  logic [IA_W-1:0] ptr_q, ptr_d;
  logic [1:0]      phase_q, phase_d;
  logic [23:0]     shift_q, shift_d;

  logic [31:0] imem_q [IMEM_WORDS];
  logic [31:0] rf_q   [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        dm_we;

  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic [31:0] rd_val, rs1_val, rs2_val;
  logic [31:0] alu_b, alu_y;
  logic [2:0]  alu_op;
  logic [31:0] dbg_word;

  assign instr   = imem_q[pc_q[IA_W-1:0]];
  assign op      = instr[31:26];
  assign rd      = instr[25:21];
  assign rs1     = instr[20:16];
  assign rs2     = instr[15:11];
  assign imm     = instr[15:0];
  assign rd_val  = rf_q[rd];
  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  // Default operand is rs1 + sext(imm), which also forms LW/SW addresses.
  always_comb begin
    alu_b  = {{16{imm[15]}}, imm};
    alu_op = ALU_ADD;
    case (op)
      OP_ORI: begin
        alu_b  = {16'h0000, imm};
        alu_op = ALU_OR;
      end
      OP_ADD: alu_b = rs2_val;
      OP_SUB: begin
        alu_b  = rs2_val;
        alu_op = ALU_SUB;
      end
`ifdef VECTOR_OPS_EN
      OP_RELU: alu_op = ALU_RELU;
      OP_MAXP: begin
        alu_b  = rs2_val;
        alu_op = ALU_MAXP;
      end
`endif
      default: ;
    endcase
  end

  cpu_vec_alu u_alu (
    .a_i  (rs1_val),
    .b_i  (alu_b),
    .op_i (alu_op),
    .y_o  (alu_y)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    imem_we    = 1'b0;
    imem_wdata = {shift_q, instr_i};
    rf_we      = 1'b0;
    rf_wdata   = alu_y;
    dm_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_i == START) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          phase_d = 2'd0;
        end
      end
      ST_LOAD: begin
        if (phase_q == 2'd0 && instr_i == END) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end else begin
          phase_d = phase_q + 2'd1;
          shift_d = {shift_q[15:0], instr_i};
          if (phase_q == 2'd3) begin
            imem_we = 1'b1;
            ptr_d   = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) begin
              state_d = ST_RUN;
              pc_d    = '0;
            end
          end
        end
      end
      ST_RUN: begin
        if (pc_q >= PC_END) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_q + PC_ONE;
          case (op)
            OP_NOP: ;
            OP_ADDI, OP_ORI, OP_ADD, OP_SUB: rf_we = 1'b1;
            OP_LUI: begin
              rf_we    = 1'b1;
              rf_wdata = {imm, 16'h0000};
            end
            OP_LW: begin
              rf_we    = 1'b1;
              rf_wdata = dmem_q[alu_y[4:0]];
            end
            OP_SW: dm_we = 1'b1;
            OP_BEQ: begin
              // PC is narrower than the 11-bit offset, so its low bits are the sign-extended offset mod 2^(IA_W+1).
              if (rd_val == rs1_val) pc_d = pc_q + PC_ONE + imm[IA_W:0];
            end
`ifdef VECTOR_OPS_EN
            OP_RELU, OP_MAXP: rf_we = 1'b1;
`endif
            OP_HALT: begin
              state_d = ST_HALT;
              pc_d    = pc_q;
            end
            default: begin
              state_d = ST_TRAP;
              pc_d    = pc_q;
            end
          endcase
        end
      end
      default: ;
    endcase
    if (rd == 5'd0) rf_we = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ptr_q   <= '0;
      phase_q <= 2'd0;
      shift_q <= '0;
      for (int i = 0; i < IMEM_WORDS; i++) imem_q[i] <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      if (imem_we) imem_q[ptr_q] <= imem_wdata;
      if (rf_we) rf_q[rd] <= rf_wdata;
      if (dm_we) dmem_q[alu_y[4:0]] <= rd_val;
    end
  end

  assign dbg_word    = DataOrReg ? rf_q[address] : dmem_q[address];
  assign value_o     = dbg_word[{vout_addr, 3'b000} +: 8];
  assign is_positive = !value_o[7] && (value_o != 8'h00);
  assign easter_egg  = state_q;

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu: program loading, vector ops, memory path, termination and reset.
module tb_cpu;
  import cpu_pkg::*;

`ifdef VECTOR_OPS_EN
  localparam logic VEC = 1'b1;
`else
  localparam logic VEC = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset;
  logic [7:0] instr_i;
  logic       DataOrReg;
  logic [4:0] address;
  logic [1:0] vout_addr;
  logic [7:0] value_o;
  logic       is_positive;
  logic [2:0] easter_egg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prog [$];

  cpu dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .instr_i     (instr_i),
    .DataOrReg   (DataOrReg),
    .address     (address),
    .vout_addr   (vout_addr),
    .value_o     (value_o),
    .is_positive (is_positive),
    .easter_egg  (easter_egg)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic rd_byte(input logic sel, input logic [4:0] a, input logic [1:0] b,
                         output logic [7:0] v, output logic p);
    DataOrReg = sel;
    address   = a;
    vout_addr = b;
    #1;
    v = value_o;
    p = is_positive;
  endtask

  task automatic chk_word(input string tag, input logic sel, input logic [4:0] a, input logic [31:0] w);
    logic [7:0] v;
    logic       p;
    for (int b = 0; b < 4; b++) begin
      rd_byte(sel, a, 2'(b), v, p);
      check($sformatf("%s.b%0d", tag, b), 32'(v), 32'(w[b*8 +: 8]));
    end
  endtask

  task automatic chk_pos(input string tag, input logic sel, input logic [4:0] a, input logic [3:0] pos);
    logic [7:0] v;
    logic       p;
    for (int b = 0; b < 4; b++) begin
      rd_byte(sel, a, 2'(b), v, p);
      check($sformatf("%s.pos%0d", tag, b), 32'(p), 32'(pos[b]));
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] expv);
    check(tag, 32'(easter_egg), 32'(expv));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] expv, input int max);
    int n = 0;
    while (easter_egg !== expv && n < max) begin
      @(negedge clk_i);
      n++;
    end
    chk_state(tag, expv);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    instr_i = b;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset   = 1'b1;
    instr_i = 8'h00;
    #2;
    reset = 1'b0;
  endtask

  task automatic load_prog(input string name);
    send_byte(START);
    @(posedge clk_i);
    #1;
    chk_state({name, ".load_entry"}, 3'b001);
    foreach (prog[i]) send_word(prog[i]);
    send_byte(END);
    @(negedge clk_i);
    instr_i = 8'h00;
    $display("program %s loaded: %0d words", name, prog.size());
  endtask

  initial begin
    logic [7:0] v;
    logic       p;
    reset     = 1'b1;
    instr_i   = 8'h00;
    DataOrReg = 1'b0;
    address   = 5'd0;
    vout_addr = 2'd0;

    // Reset and idle: everything reads zero.
    #7;
    chk_state("reset.state", 3'b000);
    for (int a = 0; a < 32; a++)
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < 4; b++) begin
          rd_byte(s[0], 5'(a), 2'(b), v, p);
          check($sformatf("reset.%s%0d.b%0d", s ? "r" : "m", a, b), 32'(v), 32'h0);
          check($sformatf("reset.%s%0d.pos%0d", s ? "r" : "m", a, b), 32'(p), 32'h0);
        end
    @(negedge clk_i);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'h00);
    send_byte(END);
    send_byte(8'h00);
    @(negedge clk_i);
    chk_state("idle.ignore", 3'b000);
    $display("reset/idle phase complete");

    // ReLU program.
    prog = '{enc(OP_LUI, 5'd2, 5'd0, 16'h807F),
             enc(OP_ORI, 5'd2, 5'd2, 16'hFF01),
             enc(OP_RELU, 5'd3, 5'd2, 16'h0000),
             enc(OP_HALT, 5'd0, 5'd0, 16'h0000)};
    load_prog("relu");
    wait_state("relu.end", VEC ? 3'b100 : 3'b111, 50);
    chk_word("relu.r2", 1'b1, 5'd2, 32'h807FFF01);
    chk_pos("relu.r2", 1'b1, 5'd2, 4'b0101);
    chk_word("relu.r3", 1'b1, 5'd3, VEC ? 32'h007F0001 : 32'h0);
    chk_pos("relu.r3", 1'b1, 5'd3, VEC ? 4'b0101 : 4'b0000);

    // MaxPool program.
    do_reset();
    prog = '{enc(OP_LUI, 5'd4, 5'd0, 16'h12F0),
             enc(OP_ORI, 5'd4, 5'd4, 16'h8005),
             enc(OP_LUI, 5'd6, 5'd0, 16'h0310),
             enc(OP_ORI, 5'd6, 5'd6, 16'hFF80),
             enc(OP_MAXP, 5'd5, 5'd4, 16'h3000),
             enc(OP_HALT, 5'd0, 5'd0, 16'h0000)};
    load_prog("maxp");
    wait_state("maxp.end", VEC ? 3'b100 : 3'b111, 50);
    chk_word("maxp.r4", 1'b1, 5'd4, 32'h12F08005);
    chk_word("maxp.r6", 1'b1, 5'd6, 32'h0310FF80);
    chk_word("maxp.r5", 1'b1, 5'd5, VEC ? 32'h1210FF05 : 32'h0);

    // Memory path, scalar ALU and a taken forward branch.
    do_reset();
    prog = '{enc(OP_ADDI, 5'd1, 5'd0, 16'h0007),
             enc(OP_SW, 5'd1, 5'd0, 16'h0003),
             enc(OP_LW, 5'd7, 5'd0, 16'h0003),
             enc(OP_ADD, 5'd8, 5'd1, 16'h0800),
             enc(OP_SUB, 5'd9, 5'd0, 16'h0800),
             enc(OP_BEQ, 5'd1, 5'd7, 16'h0001),
             enc(OP_ADDI, 5'd10, 5'd0, 16'h0001),
             enc(OP_ADDI, 5'd11, 5'd0, 16'h0002),
             enc(OP_ADDI, 5'd0, 5'd0, 16'h0005),
             enc(OP_ADDI, 5'd12, 5'd0, 16'hFFFE),
             enc(OP_HALT, 5'd0, 5'd0, 16'h0000)};
    load_prog("mem");
    wait_state("mem.end", 3'b100, 50);
    chk_word("mem.dmem3", 1'b0, 5'd3, 32'h00000007);
    chk_word("mem.dmem4", 1'b0, 5'd4, 32'h0);
    chk_word("mem.r7", 1'b1, 5'd7, 32'h00000007);
    chk_word("mem.r8", 1'b1, 5'd8, 32'h0000000E);
    chk_word("mem.r9", 1'b1, 5'd9, 32'hFFFFFFF9);
    chk_pos("mem.r9", 1'b1, 5'd9, 4'b0000);
    chk_word("mem.r10", 1'b1, 5'd10, 32'h0);
    chk_word("mem.r11", 1'b1, 5'd11, 32'h00000002);
    chk_word("mem.r0", 1'b1, 5'd0, 32'h0);
    chk_word("mem.r12", 1'b1, 5'd12, 32'hFFFFFFFE);

    // Undefined opcode traps and freezes state.
    do_reset();
    prog = '{enc(OP_ADDI, 5'd1, 5'd0, 16'h0005),
             enc(6'h3D, 5'd0, 5'd0, 16'h0000),
             enc(OP_ADDI, 5'd1, 5'd0, 16'h0009),
             enc(OP_HALT, 5'd0, 5'd0, 16'h0000)};
    load_prog("trap");
    wait_state("trap.enter", 3'b111, 50);
    repeat (5) @(negedge clk_i);
    chk_state("trap.hold", 3'b111);
    chk_word("trap.r1", 1'b1, 5'd1, 32'h00000005);

    // Full 64-word load without end marker starts RUN automatically.
    do_reset();
    send_byte(START);
    for (int i = 0; i < 64; i++) begin
      if (i == 0) send_word(enc(OP_ADDI, 5'd12, 5'd0, 16'h0033));
      else if (i == 63) send_word(enc(OP_ADDI, 5'd13, 5'd0, 16'h0044));
      else send_word(32'h0);
    end
    @(negedge clk_i);
    instr_i = 8'h00;
    chk_state("full.autorun", 3'b010);
    $display("program full loaded: 64 words");
    wait_state("full.halt", 3'b100, 100);
    chk_word("full.r12", 1'b1, 5'd12, 32'h00000033);
    chk_word("full.r13", 1'b1, 5'd13, 32'h00000044);
    send_byte(START);
    send_byte(8'h00);
    @(negedge clk_i);
    chk_state("halt.ignore", 3'b100);

    // Backward branch loop, then asynchronous reset mid-RUN.
    do_reset();
    prog = '{enc(OP_ADDI, 5'd1, 5'd0, 16'h0055),
             enc(OP_BEQ, 5'd0, 5'd0, 16'hFFFF),
             enc(OP_HALT, 5'd0, 5'd0, 16'h0000)};
    load_prog("loop");
    repeat (20) @(negedge clk_i);
    chk_state("loop.running", 3'b010);
    chk_word("loop.r1", 1'b1, 5'd1, 32'h00000055);
    @(negedge clk_i);
    #1;
    reset = 1'b1;
    #1;
    chk_state("midrun.reset.state", 3'b000);
    chk_word("midrun.reset.r1", 1'b1, 5'd1, 32'h0);
    @(negedge clk_i);
    reset = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_state("midrun.reset.idle", 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Small 32-bit, in-order processor with packed-int8 vector ops (ReLU, lane max-pool).
- Program arrives as a byte stream on instr_i, framed by start/end markers, and loads into internal instruction memory.
- After loading, the program executes one instruction per clock until HALT.
- Any register or data-memory word can be read back one byte at a time through a combinational debug port.

Parameters:
- IMEM_WORDS, 64, instruction memory depth (32-bit words).
- DMEM_WORDS, 32, data memory depth (32-bit words), addressed by 5 bits.

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
instr_i  in  8  program byte stream, sampled every rising edge
DataOrReg  in  1  debug source select: 1 = register file, 0 = data memory
address  in  5  debug register index / data-memory word index
vout_addr  in  2  debug byte select: 3 = bits[31:24] … 0 = bits[7:0]
value_o  out  8  selected debug byte (combinational)
is_positive  out  1  value_o signed > 0, i.e. bit7==0 and value_o!=0
easter_egg  out  3  controller state code

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; PC = 0; byte counter = 0.
  - All 32 registers, all DMEM words and all IMEM words are cleared to 0.
  - Outputs then reflect the cleared storage, so value_o = 0 and is_positive = 0.
- States and easter_egg codes: IDLE = 000, LOAD = 001, RUN = 010, HALT = 100, TRAP = 111.
- IDLE:
  - Ignores instr_i until it equals 0xFE (start marker).
  - On 0xFE, moves to LOAD with write pointer 0 and byte phase 0.
- LOAD:
  - Bytes are packed MSB first: phase 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - A word is written to IMEM[ptr] on its phase-3 byte; ptr then increments.
  - Byte 0xFF at phase 0 is the end marker: go to RUN next cycle with PC = 0.
  - Reaching ptr = 64 also ends loading and goes to RUN.
  - Legal opcodes never produce first byte 0xFE or 0xFF.
- RUN: one instruction per cycle.
  - Register writes become visible the following cycle; r0 reads 0 and ignores writes.
  - PC advances by 1 word unless a branch is taken.
  - PC = 64 goes to HALT.
- HALT: holds all state; only reset leaves it.
- TRAP: entered on an undefined opcode; holds state.
- instr_i is ignored in RUN, HALT and TRAP.
- Instruction format:
  - op = [31:26], rd = [25:21], rs1 = [20:16], rs2 = [15:11], imm16 = [15:0].
- Opcode semantics:
  - 0x00 NOP.
  - 0x01 ADDI: rd = rs1 + sext(imm).
  - 0x02 LUI: rd = imm << 16.
  - 0x03 ORI: rd = rs1 | zext(imm).
  - 0x04 ADD: rd = rs1 + rs2, wraps mod 2^32.
  - 0x05 SUB: rd = rs1 - rs2, wraps mod 2^32.
  - 0x06 LW: rd = DMEM[(rs1 + imm)[4:0]].
  - 0x07 SW: DMEM[(rs1 + imm)[4:0]] = rd.
  - 0x08 BEQ: if rd == rs1, PC = PC + 1 + sext(imm[10:0]).
  - 0x10 RELU: each signed byte lane of rs1 with bit7 = 1 becomes 0x00; other lanes pass unchanged; result to rd.
  - 0x11 MAXP: each lane of rd = signed max of rs1 and rs2 lanes; on equal values either lane (identical).
  - 0x3E HALT.
  - Any other opcode → TRAP.
- Debug read:
  - value_o = byte vout_addr of (DataOrReg ? RF[address] : DMEM[address]).
  - Combinational; always valid, including during RUN.
  - A same-cycle write is seen after the clock edge.

Optional Feature:
- Macro VECTOR_OPS_EN.
  - Defined: RELU and MAXP execute as specified.
  - Undefined: opcodes 0x10 and 0x11 are undefined and go to TRAP; vector datapath is not synthesized.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants;
  - state enum with its easter_egg encodings;
  - START = 0xFE and END = 0xFF markers;
  - IMEM_WORDS and DMEM_WORDS defaults.
- One sub-module, cpu_vec_alu: combinational, 32-bit a/b/op in → 32-bit result out.
  - Covers ADD, SUB, OR, RELU and MAXP as four independent 8-bit lanes where lane-wise.

Test Plan:
- Reset then idle: 0x00 bytes only → easter_egg = 000, every RF/DMEM byte reads 0x00, is_positive = 0.
- ReLU program:
  - Stream FE, LUI r2,0x807F; ORI r2,r2,0xFF01; RELU r3,r2; HALT; FF.
  - Required: r2 bytes 3..0 read 80,7F,FF,01; r3 reads 00,7F,00,01; easter_egg = 100.
  - is_positive: 1 only for r3 byte 0x7F and 0x01.
- MaxPool program:
  - r4 = 0x12F08005, r6 = 0x0310FF80, MAXP r5,r4,r6.
  - Required: r5 reads 12,10,FF,05.
- Memory path: ADDI r1,r0,7; SW r1,[r0+3]; LW r7,[r0+3]; DataOrReg = 0, address = 3 → byte 0 = 0x07; r7 byte 0 = 0x07.
- Termination:
  - Streaming 64 full words with no end marker → RUN starts automatically.
  - Opcode 0x3D → easter_egg = 111, registers frozen.
  - Reset asserted mid-RUN → immediate IDLE and all-zero readback.
